sap1_controller: RTL and testbench

- Controller-sequencer for the SAP-1 datapath. It is the initiator side of the control interface that the accumulator, B register, ALU, PC, MAR, RAM, IR and output register respond to.
- A 6-state ring counter (T1..T6) steps through fetch and execute phases.
- The current T-state and the IR opcode nibble are decoded into the 12-bit control word plus a halt signal.
- State changes on the falling clock edge, so control lines are stable at every rising edge, where the datapath registers load.

---
 rtl/sap1_ctrl_if.sv | 55 +++++
 rtl/sap1_controller.sv | 151 +++++++++++++++
 tb/tb_sap1_controller.sv | 135 +++++++++++++
 3 files changed

// File: rtl/sap1_ctrl_if.sv
// SAP-1 control interface: controller drives the control word,
// the IR supplies the opcode nibble back to the sequencer.
interface sap1_ctrl_if;
  logic [3:0] OPCODE;
  logic       Cp;
  logic       Ep;
  logic       nLm;
  logic       nCE;
  logic       nLi;
  logic       nEi;
  logic       nLa;
  logic       Ea;
  logic       Su;
  logic       Eu;
  logic       nLb;
  logic       nLo;
  logic       HLT;
  logic [5:0] TSTATE;

  modport master (
    input  OPCODE,
    output Cp,
    output Ep,
    output nLm,
    output nCE,
    output nLi,
    output nEi,
    output nLa,
    output Ea,
    output Su,
    output Eu,
    output nLb,
    output nLo,
    output HLT,
    output TSTATE
  );

  modport slave (
    output OPCODE,
    input  Cp,
    input  Ep,
    input  nLm,
    input  nCE,
    input  nLi,
    input  nEi,
    input  nLa,
    input  Ea,
    input  Su,
    input  Eu,
    input  nLb,
    input  nLo,
    input  HLT,
    input  TSTATE
  );
endinterface

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: six-state ring counter stepping on
// the falling edge, decoded with the opcode into the control word.
module sap1_controller #(
  parameter logic [3:0] OP_LDA = 4'b0000,
  parameter logic [3:0] OP_ADD = 4'b0001,
  parameter logic [3:0] OP_SUB = 4'b0010,
  parameter logic [3:0] OP_OUT = 4'b1110,
  parameter logic [3:0] OP_HLT = 4'b1111
) (
  input  logic CLK,
  input  logic CLR,
  sap1_ctrl_if.master bus
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_e;

  typedef struct packed {
    logic cp;
    logic ep;
    logic nlm;
    logic nce;
    logic nli;
    logic nei;
    logic nla;
    logic ea;
    logic su;
    logic eu;
    logic nlb;
    logic nlo;
  } ctrl_t;

  localparam ctrl_t CW_IDLE = '{
    cp:  1'b0,
    ep:  1'b0,
    nlm: 1'b1,
    nce: 1'b1,
    nli: 1'b1,
    nei: 1'b1,
    nla: 1'b1,
    ea:  1'b0,
    su:  1'b0,
    eu:  1'b0,
    nlb: 1'b1,
    nlo: 1'b1
  };

  tstate_e state;
  logic    hlt;
  ctrl_t   cw;

  logic    op_lda;
  logic    op_add;
  logic    op_sub;
  logic    op_out;
  logic    op_hlt;
  logic    op_mem;

  assign op_lda = (bus.OPCODE == OP_LDA);
  assign op_add = (bus.OPCODE == OP_ADD);
  assign op_sub = (bus.OPCODE == OP_SUB);
  assign op_out = (bus.OPCODE == OP_OUT);
  assign op_hlt = (bus.OPCODE == OP_HLT);
  assign op_mem = op_lda | op_add | op_sub;

  // Halt freezes the ring at T4; only CLR releases it.
  always_ff @(negedge CLK or posedge CLR) begin
    if (CLR) begin
      state <= T1;
      hlt   <= 1'b0;
    end else if (!hlt) begin
      unique case (state)
        T1: state <= T2;
        T2: state <= T3;
        T3: begin
          state <= T4;
          hlt   <= op_hlt;
        end
        T4: state <= T5;
        T5: state <= T6;
        T6: state <= T1;
        default: state <= T1;
      endcase
    end
  end

  always_comb begin
    cw = CW_IDLE;
    if (!hlt) begin
      unique case (state)
        T1: begin
          cw.ep  = 1'b1;
          cw.nlm = 1'b0;
        end
        T2: begin
          cw.cp = 1'b1;
        end
        T3: begin
          cw.nce = 1'b0;
          cw.nli = 1'b0;
        end
        T4: begin
          if (op_mem) begin
            cw.nei = 1'b0;
            cw.nlm = 1'b0;
          end else if (op_out) begin
            cw.ea  = 1'b1;
            cw.nlo = 1'b0;
          end
        end
        T5: begin
          if (op_mem) begin
            cw.nce = 1'b0;
            cw.nla = !op_lda;
            cw.nlb = op_lda;
          end
        end
        T6: begin
          if (op_add | op_sub) begin
            cw.eu  = 1'b1;
            cw.nla = 1'b0;
            cw.su  = op_sub;
          end
        end
        default: cw = CW_IDLE;
      endcase
    end
  end

  assign bus.Cp     = cw.cp;
  assign bus.Ep     = cw.ep;
  assign bus.nLm    = cw.nlm;
  assign bus.nCE    = cw.nce;
  assign bus.nLi    = cw.nli;
  assign bus.nEi    = cw.nei;
  assign bus.nLa    = cw.nla;
  assign bus.Ea     = cw.ea;
  assign bus.Su     = cw.su;
  assign bus.Eu     = cw.eu;
  assign bus.nLb    = cw.nlb;
  assign bus.nLo    = cw.nlo;
  assign bus.HLT    = hlt;
  assign bus.TSTATE = state;

endmodule

// File: tb/tb_sap1_controller.sv
// Directed bench for the SAP-1 controller-sequencer.
module tb_sap1_controller;

  logic CLK;
  logic CLR;
  int   total;
  int   bad;

  sap1_ctrl_if bus ();

  sap1_controller dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Word order: Cp Ep nLm nCE nLi nEi nLa Ea Su Eu nLb nLo
  localparam logic [11:0] W_IDLE = 12'b0011_1110_0011;
  localparam logic [11:0] W_T1   = 12'b0101_1110_0011;
  localparam logic [11:0] W_T2   = 12'b1011_1110_0011;
  localparam logic [11:0] W_T3   = 12'b0010_0110_0011;
  localparam logic [11:0] W_M4   = 12'b0001_1010_0011;
  localparam logic [11:0] W_LDA5 = 12'b0010_1100_0011;
  localparam logic [11:0] W_ADD5 = 12'b0010_1110_0001;
  localparam logic [11:0] W_ADD6 = 12'b0011_1100_0111;
  localparam logic [11:0] W_SUB6 = 12'b0011_1100_1111;
  localparam logic [11:0] W_OUT4 = 12'b0011_1111_0010;

  function automatic logic [18:0] obs();
    return {bus.HLT, bus.TSTATE,
            bus.Cp, bus.Ep, bus.nLm, bus.nCE,
            bus.nLi, bus.nEi, bus.nLa, bus.Ea,
            bus.Su, bus.Eu, bus.nLb, bus.nLo};
  endfunction

  task automatic chk(input string tag, input logic h,
                     input logic [5:0] t, input logic [11:0] w);
    logic [18:0] o;
    logic [18:0] e;
    o = obs();
    e = {h, t, w};
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%b required=%b", tag, o, e);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #2;
  endtask

  task automatic run_instr(input string tag, input logic [3:0] op,
                           input logic [11:0] w4,
                           input logic [11:0] w5,
                           input logic [11:0] w6);
    bus.OPCODE = op;
    tick(); chk({tag, "_t2"}, 1'b0, 6'b000010, W_T2);
    tick(); chk({tag, "_t3"}, 1'b0, 6'b000100, W_T3);
    tick(); chk({tag, "_t4"}, 1'b0, 6'b001000, w4);
    tick(); chk({tag, "_t5"}, 1'b0, 6'b010000, w5);
    tick(); chk({tag, "_t6"}, 1'b0, 6'b100000, w6);
    tick(); chk({tag, "_wrap"}, 1'b0, 6'b000001, W_T1);
  endtask

  // Bus exclusivity and one-hot ring, checked at every rising edge.
  always @(posedge CLK) begin
    int drv;
    drv = int'(bus.Ep) + int'(!bus.nCE) + int'(!bus.nEi)
        + int'(bus.Ea) + int'(bus.Eu);
    total++;
    assert (drv <= 1 && $onehot(bus.TSTATE)) else begin
      bad++;
      $error("FAIL bus_excl observed drivers=%0d tstate=%b required <=1 onehot",
             drv, bus.TSTATE);
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    CLR   = 1'b1;
    bus.OPCODE = 4'b0000;
    #12;
    chk("reset", 1'b0, 6'b000001, W_T1);
    CLR = 1'b0;

    run_instr("lda", 4'b0000, W_M4, W_LDA5, W_IDLE);
    run_instr("add", 4'b0001, W_M4, W_ADD5, W_ADD6);
    run_instr("sub", 4'b0010, W_M4, W_ADD5, W_SUB6);
    run_instr("out", 4'b1110, W_OUT4, W_IDLE, W_IDLE);
    run_instr("nop", 4'b0111, W_IDLE, W_IDLE, W_IDLE);

    // Reset mid-instruction, in T5 of an ADD.
    bus.OPCODE = 4'b0001;
    tick(); tick(); tick(); tick();
    chk("mid_t5", 1'b0, 6'b010000, W_ADD5);
    #1 CLR = 1'b1;
    #1 chk("mid_clr", 1'b0, 6'b000001, W_T1);
    CLR = 1'b0;
    tick(); chk("mid_rel", 1'b0, 6'b000010, W_T2);
    tick(); tick(); tick(); tick();
    tick(); chk("mid_wrap", 1'b0, 6'b000001, W_T1);

    // Every non-halt opcode runs to completion and wraps.
    for (int op = 0; op < 15; op++) begin
      bus.OPCODE = 4'(op);
      repeat (6) tick();
      chk($sformatf("sweep_%0d", op), 1'b0, 6'b000001, W_T1);
    end

    // Halt: freeze at T4 with everything inactive until CLR.
    bus.OPCODE = 4'b1111;
    tick(); tick();
    chk("hlt_t3", 1'b0, 6'b000100, W_T3);
    tick();
    chk("hlt_t4", 1'b1, 6'b001000, W_IDLE);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("hlt_hold_%0d", i), 1'b1, 6'b001000, W_IDLE);
    end
    #1 CLR = 1'b1;
    #1 chk("hlt_clr", 1'b0, 6'b000001, W_T1);
    CLR = 1'b0;
    tick(); chk("hlt_rel", 1'b0, 6'b000010, W_T2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
